// File: rtl/chimera_pkg.sv
// Shared types for the wide-port routing controller: route selects, address
// window rules, controller states and the window decode function.
package chimera_pkg;

    localparam int unsigned MaxNumRegions = 8;
    localparam int unsigned MaxAddrWidth  = 64;
    localparam int unsigned MaxSelWidth   = $clog2(MaxNumRegions + 1);

    typedef logic [MaxSelWidth-1:0] route_sel_t;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] start_addr;
        logic [MaxAddrWidth-1:0] end_addr;
    } region_rule_t;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StSwitch = 2'd2
    } route_state_e;

    // Lowest matching window wins; an empty window (start >= end) never matches.
    function automatic route_sel_t decode_route(
        input logic [MaxAddrWidth-1:0]         addr,
        input region_rule_t [MaxNumRegions-1:0] rules
    );
        route_sel_t sel;
        sel = '0;
        for (int k = MaxNumRegions - 1; k >= 0; k--) begin
            if ((rules[k].start_addr <= addr) && (addr < rules[k].end_addr)) begin
                sel = route_sel_t'(k + 1);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/chimera_txn_counter.sv
// Outstanding-transaction counter for one direction: counts issues up and
// completions down, flags saturation and records a sticky underflow.
module chimera_txn_counter #(
    parameter int unsigned MaxTrans = 4,
    parameter int unsigned CntWidth = $clog2(MaxTrans + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] count_o,
    output logic                full_o,
    output logic                err_underflow_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);

    logic [CntWidth-1:0] count_q;
    logic                err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // A completion with nothing in flight is spurious, even if an issue
            // lands in the same cycle.
            if (dec_i && (count_q == '0)) begin
                err_q <= 1'b1;
            end
            if (inc_i && !dec_i && (count_q != CntMax)) begin
                count_q <= count_q + 1'b1;
            end else if (!inc_i && dec_i && (count_q != '0)) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count_o         = count_q;
    assign full_o          = (count_q == CntMax);
    assign err_underflow_o = err_q;

endmodule

// File: rtl/chimera_wide_route_ctrl.sv
// Routes wide AXI AW/AR requests to NumRegions pass-through windows or the
// narrow path, enforcing same-route ordering and draining before bypass changes.
module chimera_wide_route_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NumRegions = 2,
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned MaxTrans   = 4,
    parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionStart = '0,
    parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionEnd   = '0,
    parameter int unsigned SelWidth   = $clog2(NumRegions + 1),
    parameter int unsigned CntWidth   = $clog2(MaxTrans + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    input  logic                 aw_ready_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 ar_valid_i,
    input  logic                 ar_ready_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic                 b_valid_i,
    input  logic                 b_ready_i,
    input  logic                 r_valid_i,
    input  logic                 r_ready_i,
    input  logic                 r_last_i,
    input  logic                 bypass_req_i,
    output logic [SelWidth-1:0]  aw_sel_o,
    output logic [SelWidth-1:0]  ar_sel_o,
    output logic                 aw_stall_o,
    output logic                 ar_stall_o,
    output logic                 bypass_active_o,
    output logic [CntWidth-1:0]  w_outstanding_o,
    output logic [CntWidth-1:0]  r_outstanding_o,
    output logic                 err_underflow_o
);

    route_state_e              state_q, state_d;
    logic                      bypass_q;
    logic [SelWidth-1:0]       last_aw_sel_q, last_ar_sel_q;
    region_rule_t [MaxNumRegions-1:0] rules;

    logic aw_issue, ar_issue, b_done, r_done;
    logic w_full, r_full, w_err, r_err;

    // Unused rule slots stay all-zero, i.e. empty windows.
    always_comb begin
        rules = '0;
        for (int k = 0; k < int'(NumRegions); k++) begin
            rules[k].start_addr = MaxAddrWidth'(RegionStart[k]);
            rules[k].end_addr   = MaxAddrWidth'(RegionEnd[k]);
        end
    end

    assign aw_sel_o = bypass_q ? '0 : SelWidth'(decode_route(MaxAddrWidth'(aw_addr_i), rules));
    assign ar_sel_o = bypass_q ? '0 : SelWidth'(decode_route(MaxAddrWidth'(ar_addr_i), rules));

    // A route change while transactions are in flight could reorder same-ID responses.
    assign aw_stall_o = (state_q != StRun) || w_full
                     || ((w_outstanding_o != '0) && (aw_sel_o != last_aw_sel_q));
    assign ar_stall_o = (state_q != StRun) || r_full
                     || ((r_outstanding_o != '0) && (ar_sel_o != last_ar_sel_q));

    assign aw_issue = aw_valid_i && aw_ready_i && !aw_stall_o;
    assign ar_issue = ar_valid_i && ar_ready_i && !ar_stall_o;
    assign b_done   = b_valid_i && b_ready_i;
    assign r_done   = r_valid_i && r_ready_i && r_last_i;

    chimera_txn_counter #(.MaxTrans(MaxTrans), .CntWidth(CntWidth)) i_w_counter (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .inc_i           (aw_issue),
        .dec_i           (b_done),
        .count_o         (w_outstanding_o),
        .full_o          (w_full),
        .err_underflow_o (w_err)
    );

    chimera_txn_counter #(.MaxTrans(MaxTrans), .CntWidth(CntWidth)) i_r_counter (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .inc_i           (ar_issue),
        .dec_i           (r_done),
        .count_o         (r_outstanding_o),
        .full_o          (r_full),
        .err_underflow_o (r_err)
    );

    assign err_underflow_o = w_err || r_err;
    assign bypass_active_o = bypass_q;

    // NOTE: next-state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (bypass_req_i != bypass_q) state_d = StDrain;
            StDrain:  if ((w_outstanding_o == '0) && (r_outstanding_o == '0)) state_d = StSwitch;
            StSwitch: state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StRun;
            bypass_q      <= 1'b0;
            last_aw_sel_q <= '0;
            last_ar_sel_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StSwitch) begin
                bypass_q      <= !bypass_q;
                last_aw_sel_q <= '0;
                last_ar_sel_q <= '0;
            end else begin
                if (aw_issue) last_aw_sel_q <= aw_sel_o;
                if (ar_issue) last_ar_sel_q <= ar_sel_o;
            end
        end
    end

endmodule

// File: tb/tb_chimera_wide_route_ctrl.sv
// Directed bench for chimera_wide_route_ctrl: decode table plus hand-written
// ordering, saturation, bypass drain, underflow and reset sequences.
module tb_chimera_wide_route_ctrl;

    localparam int unsigned NumRegions = 2;
    localparam int unsigned AddrWidth  = 48;
    localparam int unsigned MaxTrans   = 4;
    localparam int unsigned SelWidth   = 2;
    localparam int unsigned CntWidth   = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
    logic [AddrWidth-1:0] aw_addr_i, ar_addr_i;
    logic                 b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
    logic                 bypass_req_i;
    logic [SelWidth-1:0]  aw_sel_o, ar_sel_o;
    logic                 aw_stall_o, ar_stall_o, bypass_active_o, err_underflow_o;
    logic [CntWidth-1:0]  w_outstanding_o, r_outstanding_o;

    int n_checks = 0;
    int n_fail   = 0;

    chimera_wide_route_ctrl #(
        .NumRegions  (NumRegions),
        .AddrWidth   (AddrWidth),
        .MaxTrans    (MaxTrans),
        .RegionStart ({48'h3000, 48'h1000}),
        .RegionEnd   ({48'h4000, 48'h2000})
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .aw_valid_i      (aw_valid_i),
        .aw_ready_i      (aw_ready_i),
        .aw_addr_i       (aw_addr_i),
        .ar_valid_i      (ar_valid_i),
        .ar_ready_i      (ar_ready_i),
        .ar_addr_i       (ar_addr_i),
        .b_valid_i       (b_valid_i),
        .b_ready_i       (b_ready_i),
        .r_valid_i       (r_valid_i),
        .r_ready_i       (r_ready_i),
        .r_last_i        (r_last_i),
        .bypass_req_i    (bypass_req_i),
        .aw_sel_o        (aw_sel_o),
        .ar_sel_o        (ar_sel_o),
        .aw_stall_o      (aw_stall_o),
        .ar_stall_o      (ar_stall_o),
        .bypass_active_o (bypass_active_o),
        .w_outstanding_o (w_outstanding_o),
        .r_outstanding_o (r_outstanding_o),
        .err_underflow_o (err_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AddrWidth-1:0] aw_addr;
        logic [AddrWidth-1:0] ar_addr;
        logic [SelWidth-1:0]  exp_aw_sel;
        logic [SelWidth-1:0]  exp_ar_sel;
    } decode_vec_t;

    decode_vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        aw_valid_i = 0; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
        b_valid_i  = 0; b_ready_i  = 0; r_valid_i  = 0; r_ready_i  = 0; r_last_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        tick();
        rst_ni = 1;
    endtask

    task automatic wait_bypass(input logic value, input int budget);
        int n = 0;
        while (bypass_active_o !== value && n < budget) begin
            tick();
            n++;
        end
        check("bypass_wait", bypass_active_o, value);
    endtask

    initial begin
        idle_inputs();
        aw_addr_i = '0; ar_addr_i = '0; bypass_req_i = 0; rst_ni = 0;
        #1;
        do_reset();

        check("rst_w_out",  w_outstanding_o, 0);
        check("rst_r_out",  r_outstanding_o, 0);
        check("rst_bypass", bypass_active_o, 0);
        check("rst_err",    err_underflow_o, 0);
        check("rst_aw_stall", aw_stall_o, 0);

        // Window decode table, idle counters.
        vecs[0] = '{48'h1800, 48'h3FFF, 2'd1, 2'd2};
        vecs[1] = '{48'h4000, 48'h0FFF, 2'd0, 2'd0};
        vecs[2] = '{48'h1000, 48'h1FFF, 2'd1, 2'd1};
        vecs[3] = '{48'h2000, 48'h3000, 2'd0, 2'd2};
        vecs[4] = '{48'h2FFF, 48'h0,    2'd0, 2'd0};
        vecs[5] = '{48'h3800, 48'hFFFF_FFFF_FFFF, 2'd2, 2'd0};
        for (int i = 0; i < 6; i++) begin
            aw_addr_i = vecs[i].aw_addr;
            ar_addr_i = vecs[i].ar_addr;
            #1;
            check($sformatf("dec_aw[%0d]", i), aw_sel_o, vecs[i].exp_aw_sel);
            check($sformatf("dec_ar[%0d]", i), ar_sel_o, vecs[i].exp_ar_sel);
            check($sformatf("dec_stall[%0d]", i), {aw_stall_o, ar_stall_o}, 2'b00);
        end

        // Ordering guard on the write side.
        aw_valid_i = 1; aw_ready_i = 1; aw_addr_i = 48'h1800;
        tick();
        check("ord_w_out1", w_outstanding_o, 1);
        aw_addr_i = 48'h3000;
        #1;
        check("ord_sel2", aw_sel_o, 2);
        check("ord_stall", aw_stall_o, 1);
        tick();
        check("ord_held_cnt", w_outstanding_o, 1);
        check("ord_held_stall", aw_stall_o, 1);
        b_valid_i = 1; b_ready_i = 1;
        tick();
        b_valid_i = 0; b_ready_i = 0;
        check("ord_after_b_cnt", w_outstanding_o, 0);
        check("ord_after_b_stall", aw_stall_o, 0);
        tick();
        aw_valid_i = 0;
        check("ord_issue2_cnt", w_outstanding_o, 1);
        aw_addr_i = 48'h3400;
        #1;
        check("ord_same_route", aw_stall_o, 0);
        b_valid_i = 1; b_ready_i = 1;
        tick();
        idle_inputs();
        check("ord_clean", w_outstanding_o, 0);

        // Read-side saturation.
        ar_valid_i = 1; ar_ready_i = 1; ar_addr_i = 48'h1000;
        repeat (4) tick();
        check("sat_cnt4", r_outstanding_o, 4);
        check("sat_stall", ar_stall_o, 1);
        tick();
        check("sat_hold4", r_outstanding_o, 4);
        ar_valid_i = 0;
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1;
        tick();
        check("sat_cnt3", r_outstanding_o, 3);
        ar_valid_i = 1;
        #1;
        check("sat_unstall", ar_stall_o, 0);
        tick();
        check("sat_issue_and_done", r_outstanding_o, 3);
        ar_valid_i = 0; r_last_i = 0;
        tick();
        check("sat_non_last_beat", r_outstanding_o, 3);
        r_last_i = 1;
        repeat (3) tick();
        idle_inputs();
        check("sat_drained", r_outstanding_o, 0);

        // Bypass drain with two writes in flight.
        aw_valid_i = 1; aw_ready_i = 1; aw_addr_i = 48'h1800;
        repeat (2) tick();
        aw_valid_i = 0;
        check("byp_w_out2", w_outstanding_o, 2);
        bypass_req_i = 1;
        tick();
        check("byp_drain_stalls", {aw_stall_o, ar_stall_o}, 2'b11);
        check("byp_drain_mode", bypass_active_o, 0);
        b_valid_i = 1; b_ready_i = 1;
        repeat (2) tick();
        b_valid_i = 0; b_ready_i = 0;
        check("byp_drained_cnt", w_outstanding_o, 0);
        check("byp_drained_stall", aw_stall_o, 1);
        tick();
        check("byp_switch_stall", {aw_stall_o, ar_stall_o}, 2'b11);
        check("byp_switch_mode", bypass_active_o, 0);
        tick();
        check("byp_active", bypass_active_o, 1);
        check("byp_run_stall", {aw_stall_o, ar_stall_o}, 2'b00);
        check("byp_aw_sel", aw_sel_o, 0);
        ar_addr_i = 48'h3000;
        #1;
        check("byp_ar_sel", ar_sel_o, 0);
        bypass_req_i = 0;
        wait_bypass(1'b0, 10);
        tick();
        check("byp_off_sel", aw_sel_o, 1);

        // Sticky underflow on a spurious B.
        b_valid_i = 1; b_ready_i = 1;
        tick();
        b_valid_i = 0; b_ready_i = 0;
        check("uf_err", err_underflow_o, 1);
        check("uf_cnt", w_outstanding_o, 0);
        repeat (3) tick();
        check("uf_sticky", err_underflow_o, 1);
        do_reset();
        check("uf_cleared", err_underflow_o, 0);

        // Reset in the middle of a drain.
        aw_valid_i = 1; aw_ready_i = 1; aw_addr_i = 48'h1800;
        tick();
        aw_valid_i = 0;
        bypass_req_i = 1;
        tick();
        check("rd_in_drain", aw_stall_o, 1);
        bypass_req_i = 0;
        do_reset();
        check("rd_cnt", w_outstanding_o, 0);
        check("rd_bypass", bypass_active_o, 0);
        check("rd_stall", {aw_stall_o, ar_stall_o}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
